btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/clock_pkg.sv | 34 +++
 rtl/btn_channel.sv | 117 +++++++++++
 rtl/btn_conditioner.sv | 63 ++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants, button indices and channel FSM encoding for the
// push-button front end of the clock design.
package clock_pkg;

  localparam int CLK_HZ = 50_000_000;

  // Default timing at CLK_HZ: 10 ms debounce, 500 ms repeat delay, 100 ms rate
  localparam int DEB_CYC_DEF   = 500_000;
  localparam int DELAY_CYC_DEF = 25_000_000;
  localparam int RATE_CYC_DEF  = 5_000_000;

  // Button bit positions; (DEC_MIN, INC_MIN) and (DEC_HOUR, INC_HOUR) oppose
  localparam int NUM_BTN      = 4;
  localparam int BTN_DEC_MIN  = 0;
  localparam int BTN_INC_MIN  = 1;
  localparam int BTN_DEC_HOUR = 2;
  localparam int BTN_INC_HOUR = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Counter width able to hold max(a,b,c)-1; never narrower than one bit
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button lane: 2-flop synchronizer, debounce, IDLE/WAIT/REPEAT
// auto-repeat FSM. Exposes the next-cycle held level and raw pulse so the
// top can register a gated pulse aligned with held.
module btn_channel
  import clock_pkg::*;
#(
  parameter int DEB_CYC   = DEB_CYC_DEF,
  parameter int DELAY_CYC = DELAY_CYC_DEF,
  parameter int RATE_CYC  = RATE_CYC_DEF,
  parameter int CW        = cnt_width(DEB_CYC, DELAY_CYC, RATE_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic held,
  output logic held_nxt,
  output logic raw_pulse_nxt
);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RATE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          held_q, held_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  btn_state_e    state_q, state_d;
  logic          raw_d;
  logic          pressed_s;

  assign pressed_s     = ~sync_q[1];
  assign held          = held_q;
  assign held_nxt      = held_d;
  assign raw_pulse_nxt = raw_d;

  // Shift raw button into the synchronizer; released (1) is the idle level
  always_comb begin
    sync_d = {sync_q[0], btn_n};
  end

  // Debounce: count disagreeing samples, toggle held on the DEB_CYC-th one
  always_comb begin
    held_d    = held_q;
    deb_cnt_d = deb_cnt_q;
    if (pressed_s == held_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      held_d    = ~held_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Auto-repeat FSM, driven by the held edge being committed this cycle so
  // the first pulse lands together with held
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    raw_d     = 1'b0;
    if (held_q && !held_d) begin
      state_d   = IDLE;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (held_d && !held_q) begin
            state_d   = WAIT;
            rep_cnt_d = '0;
            raw_d     = 1'b1;
          end
        end
        WAIT: begin
          if (rep_cnt_q == DELAY_LAST) begin
            state_d   = REPEAT;
            rep_cnt_d = '0;
            raw_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rep_cnt_q == RATE_LAST) begin
            rep_cnt_d = '0;
            raw_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  // Lane state registers; reset forces released/idle so a button held
  // through reset still needs a full debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      held_q    <= 1'b0;
      deb_cnt_q <= '0;
      rep_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      held_q    <= held_d;
      deb_cnt_q <= deb_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Four-button conditioner: per-lane debounce/auto-repeat, then opposing
// pair masking and settings-mode gating into a registered pulse vector.
module btn_conditioner
  import clock_pkg::*;
#(
  parameter int DEB_CYC   = DEB_CYC_DEF,
  parameter int DELAY_CYC = DELAY_CYC_DEF,
  parameter int RATE_CYC  = RATE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               adjust_en,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] pulse
);

  localparam int CW = cnt_width(DEB_CYC, DELAY_CYC, RATE_CYC);

  logic [NUM_BTN-1:0] held_nxt;
  logic [NUM_BTN-1:0] raw_nxt;
  logic [NUM_BTN-1:0] conflict_mask;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               min_conf, hour_conf;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEB_CYC   (DEB_CYC),
      .DELAY_CYC (DELAY_CYC),
      .RATE_CYC  (RATE_CYC),
      .CW        (CW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .btn_n         (btn_n[i]),
      .held          (held[i]),
      .held_nxt      (held_nxt[i]),
      .raw_pulse_nxt (raw_nxt[i])
    );
  end

  // Mask uses next-cycle held so a pulse never shows while its pair is held
  always_comb begin
    min_conf  = held_nxt[BTN_DEC_MIN]  & held_nxt[BTN_INC_MIN];
    hour_conf = held_nxt[BTN_DEC_HOUR] & held_nxt[BTN_INC_HOUR];
    conflict_mask                = '0;
    conflict_mask[BTN_DEC_MIN]   = min_conf;
    conflict_mask[BTN_INC_MIN]   = min_conf;
    conflict_mask[BTN_DEC_HOUR]  = hour_conf;
    conflict_mask[BTN_INC_HOUR]  = hour_conf;
    // Trailing ~pulse_q keeps strobes single-cycle even for degenerate timings
    pulse_d = raw_nxt & {NUM_BTN{adjust_en}} & ~conflict_mask & ~pulse_q;
  end

  // Registered strobes toward the time-keeping core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_q <= '0;
    else      pulse_q <= pulse_d;
  end

  assign pulse = pulse_q;

endmodule
